// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared types and helpers for the partial-sum MAC stage
package psum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Full-precision width of a signed IF x filter product.
    function automatic int prod_width(input int if_w, input int filter_w);
        return if_w + filter_w;
    endfunction

    // Signed limits of a w-bit accumulator, used by the saturating build.
    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// rtl/psum_fifo.sv - output FIFO for partial sums, registered head, push/pop same cycle
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_data  write request and data (ignored when full without a pop)
//   pop              consumer takes the head this cycle
//   dout, valid      registered head data and not-empty flag
//   full, count      occupancy status
module psum_fifo
    import psum_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      cnt_after_pop;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] dout_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_next       = rd_ptr + AW'(do_pop);
        cnt_after_pop = count - (AW+1)'(do_pop);
        count_next    = cnt_after_pop + (AW+1)'(do_push);
        // The head register must follow the entry that becomes head; when
        // the FIFO would otherwise be empty, that is the word being written.
        if (cnt_after_pop == '0) begin
            dout_next = do_push ? push_data : dout;
        end else begin
            dout_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            valid  <= 1'b0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + AW'(do_push);
            count  <= count_next;
            dout   <= dout_next;
            valid  <= (count_next != '0);
        end
    end

endmodule

// File: rtl/psum_mac_stage.sv
// rtl/psum_mac_stage.sv - signed MAC with window close into an output FIFO and drain control
//
// Optional feature macro: PSUM_SATURATE_EN (saturating accumulator + sat_flag port).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   can_mult, par_done       accumulate this cycle / last product of the window
//   Done                     all windows issued, drain and finish
//   if_dout, filter_dout     signed operands from the scratchpads
//   psum_dout, psum_valid    FIFO head toward the PSUM consumer
//   psum_ready               consumer accepts the head
//   stall, busy, out_done    flow control and status
//   ovf_err                  sticky: can_mult arrived while stalled
//   sat_flag                 sticky: a sum saturated (PSUM_SATURATE_EN only)
module psum_mac_stage
    import psum_pkg::*;
#(
    parameter int IF_CELL_SIZE     = 8,
    parameter int FILTER_CELL_SIZE = 8,
    parameter int PSUM_WIDTH       = 16,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        can_mult,
    input  logic                        par_done,
    input  logic                        Done,
    input  logic [IF_CELL_SIZE-1:0]     if_dout,
    input  logic [FILTER_CELL_SIZE-1:0] filter_dout,
    output logic [PSUM_WIDTH-1:0]       psum_dout,
    output logic                        psum_valid,
    input  logic                        psum_ready,
    output logic                        stall,
    output logic                        busy,
    output logic                        out_done,
    output logic                        ovf_err
`ifdef PSUM_SATURATE_EN
    ,
    output logic                        sat_flag
`endif
);

    localparam int PW = prod_width(IF_CELL_SIZE, FILTER_CELL_SIZE);
    localparam int AW = $clog2(DEPTH);

    state_t                        state;
    state_t                        state_next;
    logic signed [PSUM_WIDTH-1:0]  acc;
    logic signed [PSUM_WIDTH-1:0]  acc_next;
    logic signed [PSUM_WIDTH-1:0]  hold_reg;
    logic signed [PSUM_WIDTH-1:0]  hold_next;
    logic signed [PSUM_WIDTH-1:0]  mac_sum;
    logic signed [PW-1:0]          prod;
    logic signed [PSUM_WIDTH-1:0]  prod_p;
    logic                          done_pend;
    logic                          done_pend_next;
    logic                          out_done_next;
    logic                          push;
    logic [PSUM_WIDTH-1:0]         push_data;
    logic                          pop;
    logic                          space;
    logic                          fifo_full;
    logic [AW:0]                   fifo_count;

    assign prod   = $signed(if_dout) * $signed(filter_dout);
    // Size cast of a signed value sign-extends or truncates to the accumulator.
    assign prod_p = PSUM_WIDTH'(prod);

`ifdef PSUM_SATURATE_EN
    localparam logic signed [PSUM_WIDTH-1:0] PSUM_MAX = PSUM_WIDTH'(sat_max(PSUM_WIDTH));
    localparam logic signed [PSUM_WIDTH-1:0] PSUM_MIN = PSUM_WIDTH'(sat_min(PSUM_WIDTH));

    logic signed [PSUM_WIDTH:0] wide_sum;
    logic                       sat_hit;

    assign wide_sum = {acc[PSUM_WIDTH-1], acc} + {prod_p[PSUM_WIDTH-1], prod_p};
    // Overflow shows as disagreement between the guard bit and the sign bit.
    assign sat_hit  = wide_sum[PSUM_WIDTH] ^ wide_sum[PSUM_WIDTH-1];
    assign mac_sum  = !sat_hit ? wide_sum[PSUM_WIDTH-1:0]
                    : (wide_sum[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX);
`else
    assign mac_sum  = acc + prod_p;
`endif

    assign pop   = psum_valid && psum_ready;
    assign space = !fifo_full || pop;
    assign busy  = (state != ST_IDLE);

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        hold_next      = hold_reg;
        done_pend_next = done_pend;
        out_done_next  = 1'b0;
        push           = 1'b0;
        push_data      = mac_sum;
        case (state)
            ST_IDLE, ST_ACC: begin
                if (can_mult) begin
                    state_next = ST_ACC;
                    if (par_done) begin
                        acc_next = '0;
                        if (space) begin
                            push = 1'b1;
                        end else begin
                            hold_next  = mac_sum;
                            state_next = ST_HOLD;
                        end
                    end else begin
                        acc_next = mac_sum;
                    end
                end
                // An unfinished window is discarded on Done; a window that
                // just overflowed into HOLD still has to be written first.
                if (Done) begin
                    acc_next = '0;
                    if (state_next == ST_HOLD) begin
                        done_pend_next = 1'b1;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_HOLD: begin
                if (Done) begin
                    done_pend_next = 1'b1;
                end
                if (space) begin
                    push           = 1'b1;
                    push_data      = hold_reg;
                    done_pend_next = 1'b0;
                    state_next     = (done_pend || Done) ? ST_DRAIN : ST_ACC;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == '0) begin
                    out_done_next = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            hold_reg  <= '0;
            done_pend <= 1'b0;
            stall     <= 1'b0;
            out_done  <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            hold_reg  <= hold_next;
            done_pend <= done_pend_next;
            stall     <= (state_next == ST_HOLD) || (state_next == ST_DRAIN);
            out_done  <= out_done_next;
            ovf_err   <= ovf_err | (can_mult & stall);
        end
    end

`ifdef PSUM_SATURATE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
        end else if (can_mult && sat_hit && (state == ST_IDLE || state == ST_ACC)) begin
            sat_flag <= 1'b1;
        end
    end
`endif

    psum_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PSUM_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .dout      (psum_dout),
        .valid     (psum_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_psum_mac_stage.sv
// tb/tb_psum_mac_stage.sv - scoreboard bench for psum_mac_stage
module tb_psum_mac_stage;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               can_mult = 1'b0;
    logic               par_done = 1'b0;
    logic               done = 1'b0;
    logic [7:0]         if_dout = '0;
    logic [7:0]         filter_dout = '0;
    logic signed [15:0] psum_dout;
    logic               psum_valid;
    logic               psum_ready = 1'b0;
    logic               stall;
    logic               busy;
    logic               out_done;
    logic               ovf_err;
`ifdef PSUM_SATURATE_EN
    logic               sat_flag;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    psum_mac_stage dut (
        .clk         (clk),
        .rst         (rst),
        .can_mult    (can_mult),
        .par_done    (par_done),
        .Done        (done),
        .if_dout     (if_dout),
        .filter_dout (filter_dout),
        .psum_dout   (psum_dout),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .stall       (stall),
        .busy        (busy),
        .out_done    (out_done),
        .ovf_err     (ovf_err)
`ifdef PSUM_SATURATE_EN
        ,
        .sat_flag    (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every accepted head is compared against the scoreboard.
    always @(negedge clk) begin
        int e;
        if (rst && psum_valid && psum_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL psum_pop: got %0d, expected no output", psum_dout);
            end else begin
                e = exp_q.pop_front();
                if (int'(psum_dout) != e) begin
                    errors++;
                    $display("FAIL psum_pop: got %0d expected %0d", psum_dout, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mac(input int a, input int b, input bit pd);
        can_mult    = 1'b1;
        par_done    = pd;
        if_dout     = a[7:0];
        filter_dout = b[7:0];
        step();
        can_mult    = 1'b0;
        par_done    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psum_dout"}, int'(psum_dout), 0);
        check({tag, "_psum_valid"}, int'(psum_valid), 0);
        check({tag, "_stall"}, int'(stall), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_out_done"}, int'(out_done), 0);
        check({tag, "_ovf_err"}, int'(ovf_err), 0);
    endtask

    initial begin
        int done_cnt;

        step();
        check_reset_outputs("reset");
        rst = 1'b1;
        psum_ready = 1'b1;
        step();

        // Single window: 12 - 10 + 7 = 9.
        exp_q.push_back(9);
        mac(3, 4, 1'b0);
        mac(-2, 5, 1'b0);
        mac(7, 1, 1'b1);
        check("single_valid_next", int'(psum_valid), 1);
        check("single_dout_next", int'(psum_dout), 9);
        wait_drain("single_drain");

        // 3 x 16129 = 48387: wraps to -17149, or clamps to 32767.
`ifdef PSUM_SATURATE_EN
        exp_q.push_back(32767);
`else
        exp_q.push_back(-17149);
`endif
        mac(127, 127, 1'b0);
        mac(127, 127, 1'b0);
        mac(127, 127, 1'b1);
        wait_drain("wrap_drain");
`ifdef PSUM_SATURATE_EN
        check("sat_flag", int'(sat_flag), 1);
`endif

        // Full FIFO: fifth window goes to HOLD.
        psum_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            exp_q.push_back(v);
            mac(v, 1, 1'b1);
        end
        check("full_stall", int'(stall), 1);
        check("full_busy", int'(busy), 1);
        mac(9, 9, 1'b0);
        check("full_ovf_err", int'(ovf_err), 1);
        psum_ready = 1'b1;
        wait_drain("full_drain");
        check("full_stall_released", int'(stall), 0);

        // Full FIFO with a pop on the closing edge: no HOLD.
        psum_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            exp_q.push_back(v * 10);
            mac(v * 10, 1, 1'b1);
        end
        psum_ready = 1'b1;
        exp_q.push_back(50);
        mac(50, 1, 1'b1);
        check("fullpop_stall", int'(stall), 0);
        wait_drain("fullpop_drain");

        // Done after two windows, ready toggling while draining.
        psum_ready = 1'b0;
        exp_q.push_back(7);
        mac(2, 3, 1'b0);
        mac(1, 1, 1'b1);
        exp_q.push_back(-16);
        mac(-4, 4, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        check("drain_busy", int'(busy), 1);
        check("drain_stall", int'(stall), 1);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            psum_ready = ~psum_ready;
            step();
            if (out_done) done_cnt++;
        end
        check("drain_out_done_pulses", done_cnt, 1);
        check("drain_busy_after", int'(busy), 0);
        check("drain_stall_after", int'(stall), 0);
        check("drain_queue", exp_q.size(), 0);

        // Asynchronous reset mid-ACC.
        psum_ready = 1'b1;
        mac(5, 5, 1'b0);
        check("midacc_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_acc");
        step();
        rst = 1'b1;
        step();

        // Asynchronous reset mid-HOLD: FIFO contents are lost.
        psum_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            mac(v, 2, 1'b1);
        end
        check("midhold_stall", int'(stall), 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        step();
        rst = 1'b1;
        psum_ready = 1'b1;
        step();
        check("post_reset_valid", int'(psum_valid), 0);

        // Fresh window after reset starts from zero.
        exp_q.push_back(4);
        mac(2, 2, 1'b1);
        wait_drain("post_reset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_mac_stage.md
# psum_mac_stage

Downstream consumer of the convolution datapath front end (checker, IF/filter scratchpads, input buffers). Each cycle the checker asserts `can_mult`, this block multiplies the current IF and filter scratchpad outputs and accumulates the signed product. On `par_done` it closes the window and pushes the partial sum into an internal output FIFO. The FIFO drains to the PSUM consumer through a valid/ready handshake; `Done` triggers a final drain and a completion pulse.

## Interface
- `IF_CELL_SIZE`, 8: IF operand width, signed.
- `FILTER_CELL_SIZE`, 8: filter operand width, signed.
- `PSUM_WIDTH`, 16: accumulator and output width, signed.
- `DEPTH`, 4: output FIFO entries, power of two, ≥2.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `can_mult`, in, 1: operands valid this cycle; accumulate.
- `par_done`, in, 1: current product is the last of the window.
- `Done`, in, 1: all windows issued; drain and finish.
- `if_dout`, in, IF_CELL_SIZE: IF scratchpad read data.
- `filter_dout`, in, FILTER_CELL_SIZE: filter scratchpad read data.
- `psum_dout`, out, PSUM_WIDTH: FIFO head.
- `psum_valid`, out, 1: FIFO not empty.
- `psum_ready`, in, 1: consumer accepts head.
- `stall`, out, 1: upstream must hold `can_mult` low.
- `busy`, out, 1: state ≠ IDLE.
- `out_done`, out, 1: one-cycle completion pulse.
- `ovf_err`, out, 1: sticky; `can_mult` seen while stalled.

## Operation
- Product: `if_dout`·`filter_dout`, signed, IF_CELL_SIZE+FILTER_CELL_SIZE bits, sign-extended or truncated to PSUM_WIDTH. Accumulation wraps modulo 2^PSUM_WIDTH, except as changed under Configuration.
- IDLE → ACC on `can_mult`; the first product is accumulated from 0.
- In ACC, each cycle with `can_mult`=1 does `acc <= acc + prod`. Cycles with `can_mult`=0 hold `acc`.
- Window close: `can_mult`=1 and `par_done`=1 in the same cycle.
  - If the FIFO has space, `acc+prod` is written to the FIFO and `acc` clears to 0. `par_done` without `can_mult` is ignored.
  - If the FIFO is full and no pop is happening that cycle, the final sum is latched into `hold_reg`. The block then goes to HOLD with `stall`=1.
- HOLD: write `hold_reg` on the first cycle the FIFO has space (pop on the same edge counts), then return to ACC. Any `can_mult` in HOLD is dropped and sets `ovf_err`.
- `Done` seen in IDLE/ACC goes to DRAIN; seen in HOLD, it is remembered and DRAIN follows the HOLD write. A nonzero unfinished `acc` is discarded.
- DRAIN: `stall`=1. When the FIFO is empty, pulse `out_done` for one cycle and return to IDLE.
- FIFO behaviour:
  - Pop when `psum_valid && psum_ready`.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Reset mid-operation clears everything; FIFO contents are lost.

## Timing
- Reset values: `psum_dout`=0, `psum_valid`=0, `stall`=0, `busy`=0, `out_done`=0, `ovf_err`=0; state IDLE, `acc`=0.
- Accumulate latency: `acc` updates at the edge sampling `can_mult`.
- Window-close latency: `par_done` sampled at edge N puts the sum in the FIFO at N; `psum_valid` is high in cycle N+1.
- `psum_dout`/`psum_valid` are registered, with no combinational path from inputs.
- `stall` is registered: it is high the cycle after entering HOLD or DRAIN, and low the cycle after leaving HOLD.
- `out_done` is high for exactly the one cycle after the FIFO empties in DRAIN.
- Consumer may hold `psum_ready` high permanently, giving one pop per cycle.

## Configuration
- `PSUM_SATURATE_EN` defined: the accumulator saturates to the signed limits of PSUM_WIDTH (+32767 / −32768 at default) instead of wrapping. A saturated window also sets a sticky `sat_flag` output (1 bit, reset 0).
- Not defined: modulo wrap; no `sat_flag` port.

## Structure
- Package `psum_pkg`:
  - state enum IDLE/ACC/HOLD/DRAIN;
  - product-width constant function;
  - signed-limit constants used by saturation.
- Sub-module `psum_fifo`: DEPTH × PSUM_WIDTH, registered output, full/empty/count, simultaneous push/pop. Top holds the FSM, MAC and `hold_reg`.

## Test plan
- Single window: products 3·4, −2·5, 7·1 with `par_done` on the third → FIFO receives 9; `psum_valid` high next cycle; popped value 9.
- Wrap: 127·127 accumulated three times (48387) → output −17149 without `PSUM_SATURATE_EN`; 32767 with `sat_flag`=1 when defined.
- Full FIFO: `psum_ready`=0, close 5 windows (values 1..5) → 4 enqueued, `stall`=1; `can_mult` during stall sets `ovf_err`. Releasing ready yields 1,2,3,4,5 in order.
- Full with simultaneous pop on close → no HOLD entry, `stall` stays 0.
- `Done` after 2 windows with ready toggling 1/0 → both sums out, then `out_done` one cycle, `busy`=0.
- Assert `rst` low mid-ACC and mid-HOLD → all outputs at reset values immediately (asynchronous), FIFO empty.
